// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, scan FSM states and ASCII constants shared by the seg7 scan controller
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_UNDER = 7'h08;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;
endpackage

// File: rtl/ascii_to_seg7.sv
// ascii_to_seg7: combinational ASCII to 7-segment decoder (seg[0]=a .. seg[6]=g, active high)
// Ports: ch (8-bit ASCII in), seg (7-bit segment code out), dp (decimal point, only with SEG7_DP_EN).
// SEG7_DP_EN: ch[7] becomes the decimal-point flag and ch[6:0] is decoded; otherwise 0x80-0xFF decode blank.
module ascii_to_seg7 (
  input  logic [7:0] ch,
  output logic [6:0] seg
`ifdef SEG7_DP_EN
  ,
  output logic       dp
`endif
);
  import seg7_pkg::*;
  logic [7:0] code;
`ifdef SEG7_DP_EN
  assign code = {1'b0, ch[6:0]};
  assign dp   = ch[7];
`else
  assign code = ch;
`endif
  always_comb
    case (code)
      8'h30:        seg = SEG_0;
      8'h31:        seg = SEG_1;
      8'h32:        seg = SEG_2;
      8'h33:        seg = SEG_3;
      8'h34:        seg = SEG_4;
      8'h35:        seg = SEG_5;
      8'h36:        seg = SEG_6;
      8'h37:        seg = SEG_7;
      8'h38:        seg = SEG_8;
      8'h39:        seg = SEG_9;
      8'h41, 8'h61: seg = SEG_A;
      8'h42, 8'h62: seg = SEG_B;
      8'h43, 8'h63: seg = SEG_C;
      8'h44, 8'h64: seg = SEG_D;
      8'h45, 8'h65: seg = SEG_E;
      8'h46, 8'h66: seg = SEG_F;
      8'h2D:        seg = SEG_DASH;
      8'h5F:        seg = SEG_UNDER;
      default:      seg = SEG_BLANK;
    endcase
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan controller with double-buffered ASCII text and guard blanking
// Ports: clk, rst_n (async active-low); enable (low forces blank); write port wr_valid/wr_ready/wr_addr/
// wr_char/wr_commit (commit copies shadow to active at the next frame boundary); seg, dig_en (one-hot),
// frame_done (pulse as the last digit's slot ends); seg_dp only when SEG7_DP_EN is defined.
module seg7_scan_ctrl #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 1000,
  parameter  int GUARD_CYC   = 4,
  localparam int AW          = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_char,
  input  logic                  wr_commit,
  output logic [6:0]            seg,
`ifdef SEG7_DP_EN
  output logic                  seg_dp,
`endif
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);
  import seg7_pkg::*;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - GUARD_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
`ifdef SEG7_DP_EN
  localparam int DW = 8;
`else
  localparam int DW = 7;
`endif
  state_t          state;
  logic [AW-1:0]   idx, nidx;
  logic [CW-1:0]   cnt;
  logic [7:0]      active [NUM_DIGITS];
  logic [7:0]      shadow [NUM_DIGITS];
  logic            pending, show_end, guard_end, wrap, commit_now;
  logic [7:0]      char_sel;
  logic [6:0]      dec_seg;
  logic [DW-1:0]   dec_word, disp;
`ifdef SEG7_DP_EN
  logic            dec_dp;
  ascii_to_seg7 u_dec (.ch(char_sel), .seg(dec_seg), .dp(dec_dp));
  assign dec_word      = {dec_dp, dec_seg};
  assign {seg_dp, seg} = disp;
`else
  ascii_to_seg7 u_dec (.ch(char_sel), .seg(dec_seg));
  assign dec_word = dec_seg;
  assign seg      = disp;
`endif
  // nidx is the digit shown after the next SHOW entry; a commit landing on that same edge must be
  // decoded from shadow so the first digit of the new frame already shows the new text.
  always_comb begin
    show_end   = state == SHOW && cnt == SHOW_LAST;
    guard_end  = state == GUARD && cnt == GUARD_LAST;
    wrap       = guard_end && idx == LAST_IDX;
    nidx       = state == GUARD ? (idx == LAST_IDX ? '0 : idx + AW'(1)) : (state == IDLE ? '0 : idx);
    commit_now = pending && (state == IDLE || (enable && wrap));
    char_sel   = commit_now ? shadow[nidx] : active[nidx];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      disp       <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
      pending    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= ASCII_SPACE;
        shadow[i] <= ASCII_SPACE;
      end
    end else begin
      frame_done <= 1'b0;
      if (wr_valid && wr_ready) begin
        if (wr_commit) begin
          pending  <= 1'b1;
          wr_ready <= 1'b0;
        end else if (int'(wr_addr) < NUM_DIGITS)
          shadow[wr_addr] <= wr_char;
      end
      if (commit_now) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
        pending  <= 1'b0;
        wr_ready <= 1'b1;
      end
      if (!enable) begin
        state  <= IDLE;
        idx    <= '0;
        cnt    <= '0;
        disp   <= '0;
        dig_en <= '0;
      end else
        case (state)
          IDLE, GUARD:
            if (state == IDLE || guard_end) begin
              state      <= SHOW;
              idx        <= nidx;
              cnt        <= '0;
              disp       <= dec_word;
              dig_en     <= ONE << nidx;
              frame_done <= wrap;
            end else
              cnt <= cnt + CW'(1);
          SHOW:
            if (show_end) begin
              state  <= GUARD;
              cnt    <= '0;
              disp   <= '0;
              dig_en <= '0;
            end else
              cnt <= cnt + CW'(1);
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with a slot-arithmetic reference model
module tb_seg7_scan_ctrl;
  localparam int N = 4;
  localparam int RD = 10;
  localparam int GC = 2;
  localparam int SC = RD - GC;
`ifdef SEG7_DP_EN
  localparam logic [6:0] B3_SEG = 7'h4F;
`else
  localparam logic [6:0] B3_SEG = 7'h00;
`endif
  logic clk = 0, rst_n = 1, enable = 0, wr_valid = 0, wr_commit = 0;
  logic [1:0] wr_addr = 0;
  logic [7:0] wr_char = 0;
  logic wr_ready, frame_done;
  logic [6:0] seg;
  logic [N-1:0] dig_en;
`ifdef SEG7_DP_EN
  logic seg_dp;
`endif
  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_char(wr_char), .wr_commit(wr_commit), .seg(seg),
`ifdef SEG7_DP_EN
    .seg_dp(seg_dp),
`endif
    .dig_en(dig_en), .frame_done(frame_done));
  initial forever #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  typedef struct { logic [7:0] ch; logic [6:0] seg; } vec_t;
  vec_t vt [26];
  int n_cmp = 0, n_bad = 0;
  int m_t;
  bit m_pend, m_fd;
  logic [7:0] m_sh [N];
  logic [7:0] m_ac [N];
  logic [6:0] cap [N];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // returns {dp, seg}; derived from character classes rather than a per-code table
  function automatic logic [7:0] mdec(input logic [7:0] c);
    logic [6:0] dt [10];
    logic [6:0] ht [6];
    logic [7:0] u;
    logic dp;
    dt = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    ht = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dp = 1'b0;
`ifdef SEG7_DP_EN
    dp = c[7];
    c[7] = 1'b0;
`endif
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (c >= 8'h30 && c <= 8'h39) return {dp, dt[int'(c) - 48]};
    if (u >= 8'h41 && u <= 8'h46) return {dp, ht[int'(u) - 65]};
    if (c == 8'h2D) return {dp, 7'h40};
    if (c == 8'h5F) return {dp, 7'h08};
    return {dp, 7'h00};
  endfunction
  function automatic void m_reset();
    m_t = -1;
    m_pend = 0;
    m_fd = 0;
    for (int i = 0; i < N; i++) begin
      m_sh[i] = 8'h20;
      m_ac[i] = 8'h20;
    end
  endfunction
  // m_t counts cycles since scanning started, modulo one frame; -1 means idle/blank
  task automatic tick();
    int ot, nt, pos, dg;
    logic [7:0] e_disp;
    logic [N-1:0] e_dig;
    @(negedge clk);
    if (!rst_n) m_reset();
    else begin
      ot = m_t;
      nt = !enable ? -1 : (ot < 0 ? 0 : (ot + 1) % (N * RD));
      if (m_pend && (ot < 0 || nt == 0)) begin
        for (int i = 0; i < N; i++) m_ac[i] = m_sh[i];
        m_pend = 0;
      end else if (wr_valid && !m_pend) begin
        if (wr_commit) m_pend = 1;
        else m_sh[wr_addr] = wr_char;
      end
      m_fd = nt == 0 && ot >= 0;
      m_t = nt;
    end
    e_disp = 0;
    e_dig = 0;
    if (m_t >= 0) begin
      pos = m_t % RD;
      dg = (m_t / RD) % N;
      if (pos < SC) begin
        e_dig = N'(1) << dg;
        e_disp = mdec(m_ac[dg]);
      end
    end
    check("seg", 32'(seg), 32'(e_disp[6:0]));
`ifdef SEG7_DP_EN
    check("seg_dp", 32'(seg_dp), 32'(e_disp[7]));
`endif
    check("dig_en", 32'(dig_en), 32'(e_dig));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("wr_ready", 32'(wr_ready), 32'(!m_pend));
  endtask
  task automatic do_write(input logic [1:0] a, input logic [7:0] c, input logic cm);
    int n = 0;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    check("wr_wait", 32'(wr_ready), 1);
    wr_valid = 1;
    wr_addr = a;
    wr_char = c;
    wr_commit = cm;
    tick();
    wr_valid = 0;
    wr_commit = 0;
  endtask
  task automatic cap_frame();
    for (int d = 0; d < N; d++) cap[d] = 'x;
    for (int i = 0; i < N * RD; i++) begin
      if (i > 0) tick();
      for (int d = 0; d < N; d++) if (dig_en == N'(1 << d)) cap[d] = seg;
    end
  endtask
  function automatic logic [7:0] pick_char();
    string s = "0123456789ABCDEFabcdef-_ ~g";
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 255));
    return s[$urandom_range(0, s.len() - 1)];
  endfunction
  initial begin
    int n, n_on, n_off, bad, shown;
    vt = '{'{8'h30, 7'h3F}, '{8'h31, 7'h06}, '{8'h32, 7'h5B}, '{8'h33, 7'h4F}, '{8'h34, 7'h66},
           '{8'h35, 7'h6D}, '{8'h36, 7'h7D}, '{8'h37, 7'h07}, '{8'h38, 7'h7F}, '{8'h39, 7'h6F},
           '{8'h41, 7'h77}, '{8'h62, 7'h7C}, '{8'h63, 7'h39}, '{8'h44, 7'h5E}, '{8'h65, 7'h79},
           '{8'h46, 7'h71}, '{8'h2D, 7'h40}, '{8'h5F, 7'h08}, '{8'h20, 7'h00}, '{8'h7E, 7'h00},
           '{8'h67, 7'h00}, '{8'hB3, B3_SEG}, '{8'h61, 7'h77}, '{8'h42, 7'h7C}, '{8'h64, 7'h5E},
           '{8'h66, 7'h71}};
    m_reset();
    #1 rst_n = 0;
    enable = 1;
    repeat (3) begin
      tick();
      check("rst_seg", 32'(seg), 0);
      check("rst_dig", 32'(dig_en), 0);
      check("rst_rdy", 32'(wr_ready), 1);
    end
    rst_n = 1;
    n_on = 0;
    n_off = 0;
    for (int i = 0; i < RD; i++) begin
      tick();
      if (dig_en == 4'b0001) n_on++;
      else if (dig_en == 4'b0000) n_off++;
    end
    check("first_slot_on", n_on, SC);
    check("first_slot_blank", n_off, GC);
    tick();
    check("second_digit", 32'(dig_en), 32'b0010);
    check("spaces_blank", 32'(seg), 0);
    do_write(0, 8'h31, 0);
    do_write(1, 8'h32, 0);
    do_write(2, 8'h41, 0);
    do_write(3, 8'h46, 0);
    do_write(0, 8'h00, 1);
    check("rdy_low_after_commit", 32'(wr_ready), 0);
    n = 0;
    while (!frame_done && n < 100) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(frame_done), 1);
    check("rdy_back", 32'(wr_ready), 1);
    cap_frame();
    check("frame_d0", 32'(cap[0]), 32'h06);
    check("frame_d1", 32'(cap[1]), 32'h5B);
    check("frame_d2", 32'(cap[2]), 32'h77);
    check("frame_d3", 32'(cap[3]), 32'h71);
    do_write(1, 8'h38, 0);
    bad = 0;
    shown = 0;
    repeat (3 * N * RD) begin
      tick();
      if (dig_en == 4'b0010) begin
        shown++;
        if (seg !== 7'h5B) bad++;
      end
    end
    check("shadow_only_bad", bad, 0);
    check("shadow_only_shown", shown, 3 * SC);
    enable = 0;
    tick();
    check("idle_dig", 32'(dig_en), 0);
    do_write(0, 8'h00, 1);
    tick();
    check("idle_commit_rdy", 32'(wr_ready), 1);
    enable = 1;
    tick();
    check("restart_d0", 32'(dig_en), 32'b0001);
    check("new_d0", 32'(seg), 32'h06);
    n = 0;
    while (dig_en != 4'b0010 && n < 20) begin
      tick();
      n++;
    end
    check("new_d1", 32'(seg), 32'h7F);
    n = 0;
    while (dig_en != 4'b0100 && n < 100) begin
      tick();
      n++;
    end
    check("reach_d2", 32'(dig_en), 32'b0100);
    tick();
    tick();
    enable = 0;
    tick();
    check("drop_seg", 32'(seg), 0);
    check("drop_dig", 32'(dig_en), 0);
    enable = 1;
    tick();
    check("reenable_d0", 32'(dig_en), 32'b0001);
    for (int v = 0; v < 26; v++) begin
      enable = 0;
      tick();
      do_write(0, vt[v].ch, 0);
      do_write(0, 8'h00, 1);
      tick();
      enable = 1;
      tick();
      check($sformatf("dec_%02h", vt[v].ch), 32'(seg), 32'(vt[v].seg));
    end
    for (int i = 0; i < 3000; i++) begin
      enable = $urandom_range(0, 99) < 97;
      wr_valid = $urandom_range(0, 3) == 0;
      wr_commit = $urandom_range(0, 4) == 0;
      wr_addr = 2'($urandom_range(0, 3));
      wr_char = pick_char();
      tick();
    end
    wr_valid = 0;
    wr_commit = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-bus multi-digit 7-segment display. It holds an ASCII character buffer written through a valid/ready port and converts each character to segment codes. It cycles one-hot digit enables with a blanking guard interval between digits. Writes are double-buffered and committed atomically at a frame boundary, so a partially updated string is never displayed.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 1000, clock cycles per digit slot (SHOW + GUARD), must exceed GUARD_CYC
GUARD_CYC, 4, blank cycles at the end of each slot (anti-ghosting)
AW, $clog2(NUM_DIGITS), localparam, digit address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled; low forces blank
wr_valid  in  1  character write request
wr_ready  out  1  controller can accept a write or commit
wr_addr  in  AW  target digit, 0 = leftmost
wr_char  in  8  ASCII code
wr_commit  in  1  with wr_valid: copy shadow buffer to active buffer at the next frame boundary
seg  out  7  segment drive, seg[0]=a .. seg[6]=g, active high
dig_en  out  NUM_DIGITS  one-hot digit enable, active high
frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 slot ends

Behaviour:
- Reset (async, rst_n=0):
  - seg=0, dig_en=0, frame_done=0, wr_ready=1.
  - Both buffers filled with 0x20 (space); digit index=0; slot counter=0; FSM=IDLE.
- FSM states: IDLE, SHOW, GUARD.
  - IDLE: outputs blank. Go to SHOW with index 0 and counter 0 on the first cycle enable=1.
  - SHOW: dig_en=1<<index; seg=decode(active[index]), registered so it is valid the same cycle dig_en asserts. After REFRESH_DIV-GUARD_CYC cycles, go to GUARD.
  - GUARD: seg=0, dig_en=0 for GUARD_CYC cycles. Then index=index+1, wrapping NUM_DIGITS-1 to 0, and return to SHOW.
  - frame_done pulses on the GUARD-to-SHOW transition when index wraps.
  - enable=0 in any state: the next cycle is IDLE with outputs blank and index reset to 0. A pending commit is kept.
- Write handshake: a transfer occurs when wr_valid && wr_ready.
  - wr_commit=0: shadow[wr_addr] <= wr_char. Out-of-range wr_addr (NUM_DIGITS not a power of 2) is accepted and dropped.
  - wr_commit=1: wr_char and wr_addr are ignored. A commit-pending flag is set and wr_ready drops the next cycle.
  - Pending commit: at the frame-boundary cycle, shadow is copied to active, the flag clears, and wr_ready returns high the following cycle.
  - When IDLE, a pending commit applies on the next cycle instead.
  - wr_valid is ignored while wr_ready=0. Requesters hold their data.
- Decode, combinational:
  - '0'-'9' -> 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - 'A'/'a' 77, 'B'/'b' 7C, 'C'/'c' 39, 'D'/'d' 5E, 'E'/'e' 79, 'F'/'f' 71.
  - '-' 40, '_' 08. Space and all other codes -> 00.
- Simultaneous write and frame boundary: with no commit pending, the shadow write occurs and the active buffer is unchanged.

Optional Feature:
SEG7_DP_EN
- Defined:
  - Adds output port seg_dp (1 bit, active high). wr_char[7] is the decimal-point flag; wr_char[6:0] is decoded.
  - seg_dp follows seg timing and blanking; reset value 0.
- Undefined:
  - No seg_dp port.
  - Codes 0x80-0xFF decode to blank.

Decomposition:
- Package seg7_pkg: segment code constants (SEG_0..SEG_F, SEG_DASH, SEG_UNDER, SEG_BLANK), the FSM state encoding (IDLE/SHOW/GUARD), and ASCII_SPACE.
- Sub-module ascii_to_seg7: combinational, 8-bit ASCII in, 7-bit seg out (plus dp under SEG7_DP_EN). Instantiated once on the active[index] read path.

Test Plan:
- Reset with enable=1 held → seg=00, dig_en=0000 while rst_n=0. After release, with NUM_DIGITS=4, REFRESH_DIV=10, GUARD_CYC=2: dig_en 0001 for 8 cycles, then 2 blank cycles, then 0010; seg=00 (spaces).
- Write "12AF" to addresses 0-3, then commit → wr_ready low until frame_done. The next frame shows seg 06, 5B, 77, 71 on dig_en 0001, 0010, 0100, 1000.
- Write '8' to addr 1 without commit → display is unchanged over 3 frames; shadow only.
- Commit while enable=0 → active updates within 2 cycles and wr_ready returns to 1. Raising enable then shows the new text starting at digit 0.
- Drop enable mid-SHOW on digit 2 → the next cycle is seg=00, dig_en=0. Re-enabling restarts at dig_en=0001.
- Write 0x7E ('~') and 'g' → seg=00. With SEG7_DP_EN, 0xB3 → seg=4F, seg_dp=1.
